// File: rtl/acq_scheduler.sv
// Acquisition search scheduler: sweeps code shifts and doppler groups over a
// tracking channel and keeps the strongest early/prompt/late correlation seen.
module acq_scheduler #(
  parameter int                DOPP_W  = 16,
  parameter int                CS_W    = 11,
  parameter int                I2Q2_W  = 32,
  parameter logic [DOPP_W-1:0] DBI     = 16'd100,
  parameter int                TIMEOUT = 2**20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [4:0]        prn_in,
  input  logic [DOPP_W-1:0] dopp_start,
  input  logic [DOPP_W-1:0] dopp_step,
  input  logic [7:0]        num_groups,
  input  logic [CS_W-1:0]   cs_step,
  input  logic [CS_W-1:0]   cs_last,
  input  logic [I2Q2_W-1:0] threshold,
  output logic              chan_reset,
  output logic [4:0]        chan_prn,
  output logic [DOPP_W-1:0] chan_doppler,
  output logic              seek_en,
  output logic [CS_W-1:0]   seek_target,
  input  logic [CS_W-1:0]   code_shift,
  input  logic              i2q2_valid,
  input  logic [I2Q2_W-1:0] i2q2_early,
  input  logic [I2Q2_W-1:0] i2q2_prompt,
  input  logic [I2Q2_W-1:0] i2q2_late,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic              timeout_err,
  output logic [I2Q2_W-1:0] best_i2q2,
  output logic [DOPP_W-1:0] best_doppler,
  output logic [CS_W-1:0]   best_cs
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_SEEK   = 3'd2;
  localparam logic [2:0] S_DWELL  = 3'd3;
  localparam logic [2:0] S_EVAL   = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [7:0]        grp_q, grp_d, ng_q, ng_d;
  logic [CS_W-1:0]   cs_q, cs_d, cs_step_q, cs_step_d, cs_last_q, cs_last_d;
  logic [DOPP_W-1:0] dstep_q, dstep_d;
  logic [I2Q2_W-1:0] thr_q, thr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [I2Q2_W-1:0] e_q, e_d, p_q, p_d, l_q, l_d;
  logic [4:0]        prn_q, prn_d;
  logic [DOPP_W-1:0] dopp_q, dopp_d;
  logic [CS_W-1:0]   seek_target_q;
  logic [I2Q2_W-1:0] best_i2q2_q, best_i2q2_d;
  logic [DOPP_W-1:0] best_dopp_q, best_dopp_d;
  logic [CS_W-1:0]   best_cs_q, best_cs_d;
  logic              found_q, found_d, found_hold_s;
  logic              timeout_q, timeout_d;
  logic              busy_q, done_q, chan_reset_q, seek_en_q;

  logic [I2Q2_W-1:0] sel_val_s;
  logic [DOPP_W-1:0] sel_dopp_s;
  logic [CS_W:0]     cs_sum_s;
  logic [8:0]        grp_inc_s;

  // Tap selection: prompt wins every tie, early beats late on a tie
  always_comb begin
    sel_val_s  = p_q;
    sel_dopp_s = dopp_q;
    if ((e_q > p_q) && (e_q >= l_q)) begin
      sel_val_s  = e_q;
      sel_dopp_s = dopp_q + DBI;
    end else if ((l_q > p_q) && (l_q > e_q)) begin
      sel_val_s  = l_q;
      sel_dopp_s = dopp_q - DBI;
    end else begin
      sel_val_s  = p_q;
      sel_dopp_s = dopp_q;
    end
  end

  // Extra carry bit exposes code-shift overflow when stepping past the top
  always_comb begin
    cs_sum_s  = {1'b0, cs_q} + {1'b0, cs_step_q};
    grp_inc_s = {1'b0, grp_q} + 9'd1;
  end

  // Search sequencing and next-state values for all latched context
  always_comb begin
    state_d      = state_q;
    grp_d        = grp_q;
    ng_d         = ng_q;
    cs_d         = cs_q;
    cs_step_d    = cs_step_q;
    cs_last_d    = cs_last_q;
    dstep_d      = dstep_q;
    thr_d        = thr_q;
    cnt_d        = cnt_q;
    e_d          = e_q;
    p_d          = p_q;
    l_d          = l_q;
    prn_d        = prn_q;
    dopp_d       = dopp_q;
    best_i2q2_d  = best_i2q2_q;
    best_dopp_d  = best_dopp_q;
    best_cs_d    = best_cs_q;
    timeout_d    = timeout_q;
    found_hold_s = found_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          prn_d        = prn_in;
          dopp_d       = dopp_start;
          dstep_d      = dopp_step;
          ng_d         = (num_groups == 8'd0) ? 8'd1 : num_groups;
          cs_step_d    = (cs_step == '0) ? CS_W'(1) : cs_step;
          cs_last_d    = cs_last;
          thr_d        = threshold;
          best_i2q2_d  = '0;
          timeout_d    = 1'b0;
          found_hold_s = 1'b0;
          grp_d        = 8'd0;
          cs_d         = '0;
          state_d      = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (abort) begin
          state_d = S_FINISH;
        end else begin
          cnt_d   = '0;
          state_d = S_SEEK;
        end
      end
      S_SEEK: begin
        if (abort) begin
          state_d = S_FINISH;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (code_shift == seek_target_q) ? S_DWELL : S_SEEK;
        end
      end
      S_DWELL: begin
        if (abort) begin
          state_d = S_FINISH;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end else if (i2q2_valid) begin
          e_d     = i2q2_early;
          p_d     = i2q2_prompt;
          l_d     = i2q2_late;
          state_d = S_EVAL;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_DWELL;
        end
      end
      S_EVAL: begin
        if (abort) begin
          state_d = S_FINISH;
        end else if (sel_val_s > best_i2q2_q) begin
          best_i2q2_d = sel_val_s;
          best_dopp_d = sel_dopp_s;
          best_cs_d   = cs_q;
          state_d     = S_NEXT;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (abort) begin
          state_d = S_FINISH;
        end else if (!cs_sum_s[CS_W] && (cs_sum_s[CS_W-1:0] <= cs_last_q)) begin
          cs_d    = cs_sum_s[CS_W-1:0];
          state_d = S_SETUP;
        end else if (grp_inc_s < {1'b0, ng_q}) begin
          cs_d    = '0;
          grp_d   = grp_inc_s[7:0];
          dopp_d  = dopp_q + dstep_q;
          state_d = S_SETUP;
        end else begin
          cs_d    = '0;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Detection verdict is resolved on the way into FINISH so it lines up with done
  always_comb begin
    found_d = (state_d == S_FINISH) ? (!timeout_d && (best_i2q2_d >= thr_q)) : found_hold_s;
  end

  // State, context and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      grp_q         <= 8'd0;
      ng_q          <= 8'd0;
      cs_q          <= '0;
      cs_step_q     <= '0;
      cs_last_q     <= '0;
      dstep_q       <= '0;
      thr_q         <= '0;
      cnt_q         <= '0;
      e_q           <= '0;
      p_q           <= '0;
      l_q           <= '0;
      prn_q         <= 5'd0;
      dopp_q        <= '0;
      seek_target_q <= '0;
      best_i2q2_q   <= '0;
      best_dopp_q   <= '0;
      best_cs_q     <= '0;
      found_q       <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      chan_reset_q  <= 1'b0;
      seek_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grp_q        <= grp_d;
      ng_q         <= ng_d;
      cs_q         <= cs_d;
      cs_step_q    <= cs_step_d;
      cs_last_q    <= cs_last_d;
      dstep_q      <= dstep_d;
      thr_q        <= thr_d;
      cnt_q        <= cnt_d;
      e_q          <= e_d;
      p_q          <= p_d;
      l_q          <= l_d;
      prn_q        <= prn_d;
      dopp_q       <= dopp_d;
      best_i2q2_q  <= best_i2q2_d;
      best_dopp_q  <= best_dopp_d;
      best_cs_q    <= best_cs_d;
      found_q      <= found_d;
      timeout_q    <= timeout_d;
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_FINISH);
      chan_reset_q <= (state_d == S_SETUP);
      seek_en_q    <= (state_d == S_SEEK);
      if (state_d == S_SEEK) begin
        seek_target_q <= cs_d;
      end
    end
  end

  assign chan_reset   = chan_reset_q;
  assign chan_prn     = prn_q;
  assign chan_doppler = dopp_q;
  assign seek_en      = seek_en_q;
  assign seek_target  = seek_target_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign found        = found_q;
  assign timeout_err  = timeout_q;
  assign best_i2q2    = best_i2q2_q;
  assign best_doppler = best_dopp_q;
  assign best_cs      = best_cs_q;

endmodule

// File: doc/acq_scheduler.md
ACQ_SCHEDULER -- requirements
Module: acq_scheduler

Interface
REQ-001 SHALL have parameters: DOPP_W, default 16, doppler increment width; CS_W, default 11, code-shift width; I2Q2_W, default 32, power width; DBI, default 16'd100, doppler bin increment between early/prompt/late; TIMEOUT, default 2**20, max dwell cycles.
REQ-002 SHALL have ports (clock and reset first): clk in 1 system clock; reset in 1 asynchronous active-low reset.
REQ-003 SHALL have ports: start in 1 one-cycle search request; abort in 1 one-cycle cancel; prn_in in 5 satellite PRN; dopp_start in DOPP_W first prompt doppler; dopp_step in DOPP_W prompt increment per doppler group; num_groups in 8 doppler groups to search (0 means 1); cs_step in CS_W code-shift increment; cs_last in CS_W final code-shift to test; threshold in I2Q2_W detection level.
REQ-004 SHALL have channel-side ports: chan_reset out 1; chan_prn out 5; chan_doppler out DOPP_W; seek_en out 1; seek_target out CS_W; code_shift in CS_W; i2q2_valid in 1; i2q2_early/i2q2_prompt/i2q2_late in I2Q2_W each.
REQ-005 SHALL have status ports: busy out 1; done out 1 one-cycle pulse; found out 1; timeout_err out 1; best_i2q2 out I2Q2_W; best_doppler out DOPP_W; best_cs out CS_W.

Function
REQ-006 SHALL implement FSM states IDLE, SETUP, SEEK, DWELL, EVAL, NEXT, FINISH.
REQ-007 IDLE: on start, SHALL latch all search inputs, clear best_i2q2 to 0, clear found/timeout_err, set group index 0, cs index 0, chan_doppler=dopp_start, go SETUP; start while busy SHALL be ignored.
REQ-008 SETUP: SHALL assert chan_reset for exactly one cycle with chan_prn=latched prn, then go SEEK.
REQ-009 SEEK: SHALL drive seek_en=1, seek_target=current cs; SHALL go DWELL on the first cycle code_shift==seek_target, deasserting seek_en that cycle.
REQ-010 DWELL: SHALL wait for i2q2_valid; i2q2_valid in any other state SHALL be ignored; SHALL count cycles in SEEK+DWELL and on reaching TIMEOUT set timeout_err=1 and go FINISH.
REQ-011 EVAL (entered one cycle after i2q2_valid, values registered on the valid cycle): SHALL select the maximum of early/prompt/late, ties resolved prompt > early > late.
REQ-012 EVAL: if selected value strictly exceeds best_i2q2, SHALL update best_i2q2, best_cs=current cs, best_doppler=chan_doppler+DBI (early), chan_doppler (prompt) or chan_doppler-DBI (late), modulo 2**DOPP_W.
REQ-013 NEXT: if cs+cs_step <= cs_last without CS_W overflow, SHALL advance cs and go SETUP; else SHALL reset cs to 0 and, if group index+1 < max(num_groups,1), add dopp_step to chan_doppler (wrapping modulo 2**DOPP_W) and go SETUP; else go FINISH.
REQ-014 FINISH: SHALL set found=(best_i2q2 >= threshold) unless timeout_err, pulse done for one cycle, return to IDLE.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 abort in any non-IDLE state SHALL go directly to FINISH in the next cycle, keeping best_* values; abort in IDLE SHALL be ignored; abort and start in same IDLE cycle: start wins.
REQ-017 Outputs best_*, found, timeout_err SHALL hold until the next accepted start.
REQ-018 Total dwells SHALL equal max(num_groups,1) x (floor(cs_last/cs_step)+1); cs_step=0 SHALL be treated as 1.

Reset
REQ-019 On reset low, asynchronously: state IDLE; busy, done, found, timeout_err, chan_reset, seek_en 0; chan_prn, chan_doppler, seek_target, best_i2q2, best_doppler, best_cs 0; counters 0.
REQ-020 Reset asserted mid-search SHALL abandon the search with no done pulse; deassertion SHALL take effect synchronously on the next clk edge.

Verification
REQ-021 start with num_groups=1, cs_step=1, cs_last=3, model returns prompt=10,20,50,5 -> 4 dwells, done once, best_i2q2=50, best_cs=2, best_doppler=dopp_start.
REQ-022 early=prompt=80 at one dwell, late=79 -> best_doppler=chan_doppler (prompt tie wins); early=90 alone -> best_doppler=chan_doppler+DBI.
REQ-023 num_groups=3, dopp_step=300, dopp_start=16'hFF00 -> chan_doppler sequence FF00, 002C, 0158 (wrapped), chan_reset pulsed before every dwell.
REQ-024 code_shift never matches seek_target with TIMEOUT=64 -> timeout_err=1, found=0, done pulse 64 cycles after SEEK entry.
REQ-025 abort during DWELL of 2nd dwell -> FINISH next cycle, done pulse, best_* from dwell 1; reset low during DWELL -> all outputs 0 immediately, no done.
